bayes_argmax_acc: RTL and testbench

BAYES_ARGMAX_ACC -- requirements
Module: bayes_argmax_acc

---
 rtl/bayes_argmax_acc.sv | 176 +++++++++++++++++
 tb/tb_bayes_argmax_acc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bayes_argmax_acc.sv
`default_nettype none
// ============================================================================
// Module   : bayes_argmax_acc
// Purpose  : Naive-Bayes classifier back end. Accumulates 784 log-likelihood
//            beats per class for ten classes and keeps the arg-max class and
//            its score.
// Options  : BAYES_PRIOR_EN - adds a prior_vec port; each class score gets
//            its signed log prior added before the compare.
// Revision : 1.0 - initial release
// ============================================================================
module bayes_argmax_acc (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         ena_pxc,
  input  logic [3:0]   c_idx,
  input  logic [9:0]   attri_idx,
  input  logic [15:0]  pxc_data,
`ifdef BAYES_PRIOR_EN
  input  logic [159:0] prior_vec,
`endif
  output logic         busy,
  output logic         done,
  output logic [3:0]   class_out,
  output logic [25:0]  best_score,
  output logic         err
);

  localparam int ACC_W = 26;

  localparam logic [3:0]       MAX_CLASS = 4'd9;
  localparam logic [9:0]       NUM_ATTR  = 10'd784;
  localparam logic [9:0]       LAST_ATTR = 10'd783;
  localparam logic [9:0]       END_MARK  = 10'd784;
  localparam logic signed [ACC_W-1:0] BEST_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state;
  logic                    d_ena;
  logic [3:0]              d_cidx;
  logic [9:0]              d_attri;
  logic signed [ACC_W-1:0] acc;
  logic [9:0]              beat_cnt;
  logic [3:0]              class_cnt;
  logic [3:0]              cls_idx;    // class index seen on the closing beat
  logic signed [ACC_W-1:0] best;

  logic signed [ACC_W-1:0] pxc_ext;
  logic signed [ACC_W-1:0] prior_ext;
  logic signed [ACC_W-1:0] score;
  logic                    d_valid_cls;
  logic                    d_marker;

  assign pxc_ext     = {{(ACC_W-16){pxc_data[15]}}, pxc_data};
  assign d_valid_cls = (d_cidx <= MAX_CLASS);
  assign d_marker    = d_ena && d_valid_cls && (d_attri == END_MARK);
  assign best_score  = best;

`ifdef BAYES_PRIOR_EN
  // Select and sign-extend the log prior of the class being compared.
  always_comb begin
    prior_ext = '0;
    for (int k = 0; k < 10; k++) begin
      if (cls_idx == 4'(k)) begin
        prior_ext = {{(ACC_W-16){prior_vec[16*k+15]}}, prior_vec[16*k +: 16]};
      end
    end
  end
`else
  assign prior_ext = '0;
`endif

  assign score = acc + prior_ext;

  // Delay the read-issue qualifiers one cycle so they line up with ROM data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      d_ena   <= 1'b0;
      d_cidx  <= '0;
      d_attri <= '0;
    end else begin
      d_ena   <= ena_pxc;
      d_cidx  <= c_idx;
      d_attri <= attri_idx;
    end
  end

  // Control FSM, per-class accumulation and running arg-max.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      class_out <= '0;
      best      <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
      class_cnt <= '0;
      cls_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // A start in any state, including DONE, restarts the vector.
        state     <= S_ACCUM;
        busy      <= 1'b1;
        err       <= 1'b0;
        best      <= BEST_MIN;
        acc       <= '0;
        beat_cnt  <= '0;
        class_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_ACCUM: begin
            if (d_ena) begin
              if (!d_valid_cls) begin
                err <= 1'b1;
              end else if (d_attri == END_MARK) begin
                // Early end of vector: the class counter is below ten here.
                err   <= 1'b1;
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                acc      <= acc + pxc_ext;
                beat_cnt <= beat_cnt + 10'd1;
                if (d_attri == LAST_ATTR) begin
                  state   <= S_CMP;
                  cls_idx <= d_cidx;
                end
              end
            end
          end
          S_CMP: begin
            if ((beat_cnt != NUM_ATTR) || (cls_idx != class_cnt)) begin
              err <= 1'b1;
            end
            // Strict compare: classes arrive in order, so ties keep the lower.
            if (score > best) begin
              best      <= score;
              class_out <= cls_idx;
            end
            acc       <= '0;
            beat_cnt  <= '0;
            class_cnt <= class_cnt + 4'd1;
            if (d_marker) begin
              err <= 1'b1;
            end
            if ((class_cnt == MAX_CLASS) || d_marker) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_ACCUM;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bayes_argmax_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_bayes_argmax_acc
// Purpose  : Directed self-checking bench for bayes_argmax_acc. A ROM model
//            returns data one cycle after each issued read; expected results
//            are queued per vector and matched against each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bayes_argmax_acc;

  logic         clk;
  logic         rstn;
  logic         start;
  logic         ena_pxc;
  logic [3:0]   c_idx;
  logic [9:0]   attri_idx;
  logic [15:0]  pxc_data;
`ifdef BAYES_PRIOR_EN
  logic [159:0] prior_vec;
`endif
  logic         busy;
  logic         done;
  logic [3:0]   class_out;
  logic [25:0]  best_score;
  logic         err;

  bayes_argmax_acc dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .ena_pxc    (ena_pxc),
    .c_idx      (c_idx),
    .attri_idx  (attri_idx),
    .pxc_data   (pxc_data),
`ifdef BAYES_PRIOR_EN
    .prior_vec  (prior_vec),
`endif
    .busy       (busy),
    .done       (done),
    .class_out  (class_out),
    .best_score (best_score),
    .err        (err)
  );

  typedef struct {
    int cls;
    int score;
    int err;
    bit lat;
  } exp_t;

  typedef struct {
    logic [3:0]  cls;
    logic [25:0] score;
    logic        err;
    logic        busy;
    int          cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_issue = 0;
  int          mode     = 0;
  logic [15:0] next_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every done pulse together with the outputs of that cycle.
  always @(negedge clk) begin
    if (done === 1'b1) obs_q.push_back('{class_out, best_score, err, busy, cyc});
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ROM contents for each test pattern.
  function automatic logic [15:0] rom(input int m, input int c, input int a);
    if (a >= 784) return 16'h0000;
    case (m)
      1: return (c == 3) ? 16'h0001 : 16'h0000;
      2: return (c == 9) ? 16'hFFFC : 16'hFFFB;
      3: return (c == 2) ? 16'h0002 : ((c == 1) ? 16'h0001 : 16'h0000);
      default: return 16'h0000;
    endcase
  endfunction

  // One clock of upstream activity; data follows its read by one cycle.
  task automatic step(input logic e, input int c, input int a);
    @(posedge clk);
    #1;
    pxc_data  = next_data;
    ena_pxc   = e;
    c_idx     = 4'(c);
    attri_idx = 10'(a);
    next_data = e ? rom(mode, c, a) : 16'h0000;
    if (e && c == 9 && a == 783) last_issue = cyc;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1;
    start    = 1'b1;
    ena_pxc  = 1'b0;
    pxc_data = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
  endtask

  task automatic sweep(input int nclasses);
    for (int c = 0; c < nclasses; c++) begin
      for (int a = 0; a < 784; a++) step(1'b1, c, a);
      step(1'b0, 0, 0);
    end
  endtask

  // Wait (bounded) for a done pulse and compare it against the queued result.
  task automatic collect(input string tag);
    exp_t e;
    obs_t o;
    int   waited;
    waited = 0;
    while (obs_q.size() == 0 && waited < 40) begin
      step(1'b0, 0, 0);
      waited++;
    end
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, (obs_q.size() > 0) ? 1 : 0, 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check({tag, "_class"}, 32'(o.cls), e.cls);
      check({tag, "_score"}, $signed(o.score), e.score);
      check({tag, "_err"}, 32'(o.err), e.err);
      check({tag, "_busy_low"}, 32'(o.busy), 0);
      if (e.lat) check({tag, "_latency"}, o.cyc - last_issue, 3);
    end
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    check({tag, "_single_pulse"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    ena_pxc   = 1'b0;
    c_idx     = '0;
    attri_idx = '0;
    pxc_data  = '0;
`ifdef BAYES_PRIOR_EN
    prior_vec = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_class", class_out, 0);
    check("rst_score", $signed(best_score), 0);
    rstn = 1'b1;
    step(1'b0, 0, 0);

    // All-zero data: every class ties, lowest class wins.
    mode = 0;
    exp_q.push_back('{0, 0, 0, 1'b1});
    do_start();
    sweep(10);
    collect("zeros");

    // Class 3 gets +1 per attribute.
    mode = 1;
    exp_q.push_back('{3, 784, 0, 1'b1});
    do_start();
    sweep(10);
    collect("class3");

    // All negative, class 9 least negative.
    mode = 2;
    exp_q.push_back('{9, -3136, 0, 1'b1});
    do_start();
    sweep(10);
    collect("neg");

    // End-of-vector marker after four classes.
    mode = 3;
    exp_q.push_back('{2, 1568, 1, 1'b0});
    do_start();
    sweep(4);
    step(1'b1, 4, 784);
    collect("marker");

    // Reset in the middle of class 5, then a clean sweep.
    mode = 1;
    do_start();
    sweep(5);
    for (int a = 0; a < 100; a++) step(1'b1, 5, a);
    @(posedge clk);
    #1;
    rstn    = 1'b0;
    ena_pxc = 1'b0;
    repeat (2) step(1'b0, 0, 0);
    check("midrst_busy", busy, 0);
    check("midrst_score", $signed(best_score), 0);
    rstn = 1'b1;
    repeat (10) step(1'b0, 0, 0);
    check("midrst_no_done", obs_q.size(), 0);
    exp_q.push_back('{3, 784, 0, 1'b1});
    do_start();
    sweep(10);
    collect("after_rst");

`ifdef BAYES_PRIOR_EN
    // Priors only: class 7 has +10.
    mode = 0;
    prior_vec = '0;
    prior_vec[7*16 +: 16] = 16'd10;
    exp_q.push_back('{7, 10, 0, 1'b1});
    do_start();
    sweep(10);
    collect("prior");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
